run_monitor_dump: RTL

Hardware end-of-run controller for the pipelined MIPS core. It watches the decode-stage instruction for the halt word and counts run cycles under a timeout. After a parametrised pipeline-drain interval it freezes the core, then streams the whole data memory out over a valid/ready port. This replaces bench-side halt polling and memory dumping, so the same sequence works in simulation and on silicon with any memory width or depth.

---
 rtl/run_monitor_dump_if.sv | 25 ++
 rtl/run_monitor_dump.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/run_monitor_dump_if.sv
// Bus bundle between the end-of-run controller, the data-memory read port and the dump consumer.
// dump_* is a valid/ready stream: a word moves on every cycle with dump_valid & dump_ready, and the word stays stable while dump_ready is low.
interface run_monitor_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;

  modport master (
    output mem_rd_en, mem_rd_addr, dump_valid, dump_data, dump_addr, dump_last,
    input  mem_rd_data, dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, dump_valid, dump_data, dump_addr, dump_last,
    output mem_rd_data, dump_ready
  );
endinterface

// File: rtl/run_monitor_dump.sv
// End-of-run controller: detects halt or timeout, drains the pipeline, freezes the core
// and streams the data memory out over the dump port.
module run_monitor_dump #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 9,
  parameter int                DUMP_WORDS   = 512,
  parameter logic [DATA_W-1:0] HALT_WORD    = DATA_W'(32'h0000_0001),
  parameter int                DRAIN_CYCLES = 4,
  parameter int                TIMEOUT      = 100000,
  parameter int                CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] instr_d,
  run_monitor_dump_if.master bus,
  output logic              cpu_freeze,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              halted,
  output logic              timed_out,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
  } state_t;

  localparam int                DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam bit                NO_DRAIN     = (DRAIN_CYCLES == 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DUMP_WORDS - 1);

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                halted_q, timed_out_q, done_q;

  logic                rd_en_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic                is_halt, is_timeout, is_last;
  logic [CNT_W-1:0]    count_inc;

  assign is_halt    = (instr_d == HALT_WORD);
  assign is_timeout = (count_q == TIMEOUT_LAST);
  assign is_last    = (addr_q == LAST_ADDR);
  assign count_inc  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (is_halt || is_timeout) state_d = NO_DRAIN ? S_DUMP_RD : S_DRAIN;
      end
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DUMP_RD;
      S_DUMP_RD: begin
        rd_en_c = 1'b1;
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: state_d = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            // Next read is issued in the accept cycle so the word rate stays at one per two cycles.
            rd_en_c   = 1'b1;
            rd_addr_c = addr_q + ADDR_W'(1);
            state_d   = S_DUMP_WAIT;
          end
        end
      end
      S_DONE: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      count_q     <= '0;
      rd_addr_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_RUN) begin
        count_q     <= '0;
        halted_q    <= 1'b0;
        timed_out_q <= 1'b0;
        done_q      <= 1'b0;
      end
      if (state_q == S_RUN) begin
        count_q <= count_inc;
        drain_q <= '0;
        // Halt takes priority when both end conditions land on the same edge.
        if (is_halt)         halted_q    <= 1'b1;
        else if (is_timeout) timed_out_q <= 1'b1;
      end
      if (state_q == S_DRAIN) begin
        count_q <= count_inc;
        drain_q <= drain_q + DRAIN_W'(1);
      end
      if (rd_en_c) rd_addr_q <= rd_addr_c;
      if (state_q == S_DUMP_WAIT) begin
        data_q <= bus.mem_rd_data;
        addr_q <= rd_addr_q;
      end
      if (state_q == S_DUMP_OUT && state_d == S_DONE) done_q <= 1'b1;
    end
  end

  assign bus.mem_rd_en   = rd_en_c;
  assign bus.mem_rd_addr = rd_addr_c;
  assign bus.dump_valid  = (state_q == S_DUMP_OUT);
  assign bus.dump_data   = data_q;
  assign bus.dump_addr   = addr_q;
  assign bus.dump_last   = (state_q == S_DUMP_OUT) && is_last;

  assign cpu_freeze  = (state_q == S_DUMP_RD) || (state_q == S_DUMP_WAIT) ||
                       (state_q == S_DUMP_OUT) || (state_q == S_DONE);
  assign cycle_count = count_q;
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
